// File: rtl/tcp_conn_ctrl.sv
// Client-side TCP connection sequencer. It runs the open, data and close
// handshakes, picks the flag set for the segment encoder, holds one payload
// until the peer acknowledges it, and retransmits on timeout up to a retry cap.
module tcp_conn_ctrl #(
  parameter int PAYLOAD_LEN      = 262,
  parameter int TIMEOUT_CYCLES   = 1000,
  parameter int MAX_RETRY        = 3,
  parameter int TIME_WAIT_CYCLES = 2000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     open_req,
  input  logic                     close_req,
  input  logic                     tx_valid,
  input  logic [PAYLOAD_LEN*8-1:0] tx_data,
  output logic                     tx_ready,
  output logic                     tx_done,
  input  logic                     rx_seg_valid,
  input  logic [5:0]               rx_seg_flag,
  output logic                     enc_en,
  output logic [5:0]               enc_flag,
  output logic [PAYLOAD_LEN*8-1:0] enc_data,
  output logic [2:0]               state,
  output logic                     established,
  output logic                     conn_err
);

  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TW_W  = (TIME_WAIT_CYCLES > 1) ? $clog2(TIME_WAIT_CYCLES) : 1;
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [5:0] FL_FIN    = 6'b000001;
  localparam logic [5:0] FL_SYN    = 6'b000010;
  localparam logic [5:0] FL_ACK    = 6'b010000;
  localparam logic [5:0] FL_SYNACK = 6'b010010;
  localparam logic [5:0] FL_PSHACK = 6'b011000;
  localparam logic [5:0] FL_FINACK = 6'b010001;

  typedef enum logic [2:0] {
    S_CLOSED     = 3'd0,
    S_SYN_SENT   = 3'd1,
    S_ESTAB      = 3'd2,
    S_WAIT_ACK   = 3'd3,
    S_FIN_WAIT_1 = 3'd4,
    S_FIN_WAIT_2 = 3'd5,
    S_TIME_WAIT  = 3'd6
  } state_e;

  state_e                   state_q, state_d;
  logic [TMR_W-1:0]         timer_q, timer_d;
  logic [TW_W-1:0]          tw_q, tw_d;
  logic [RTY_W-1:0]         retry_q, retry_d;
  logic                     enc_en_q, enc_en_d;
  logic [5:0]               enc_flag_q, enc_flag_d;
  logic [PAYLOAD_LEN*8-1:0] enc_data_q, enc_data_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;

  logic timeout;
  logic retx;
  logic peer_rst;

  assign timeout  = (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));
  assign peer_rst = rx_seg_valid && rx_seg_flag[2];

  // Next-state, issue and counter decisions for the connection sequencer.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    timer_d    = '0;
    tw_d       = '0;
    retry_d    = retry_q;
    enc_en_d   = 1'b0;
    enc_flag_d = enc_flag_q;
    enc_data_d = enc_data_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    retx       = 1'b0;

    case (state_q)
      S_CLOSED: begin
        if (open_req) begin
          enc_en_d   = 1'b1;
          enc_flag_d = FL_SYN;
          state_d    = S_SYN_SENT;
        end
      end
      S_SYN_SENT: begin
        timer_d = timer_q + 1'b1;
        if (rx_seg_valid && rx_seg_flag == FL_SYNACK) begin
          enc_en_d   = 1'b1;
          enc_flag_d = FL_ACK;
          state_d    = S_ESTAB;
        end else if (timeout) begin
          retx = 1'b1;
        end
      end
      S_ESTAB: begin
        if (tx_valid) begin
          enc_data_d = tx_data;
          enc_en_d   = 1'b1;
          enc_flag_d = FL_PSHACK;
          state_d    = S_WAIT_ACK;
        end else if (close_req) begin
          enc_en_d   = 1'b1;
          enc_flag_d = FL_FINACK;
          state_d    = S_FIN_WAIT_1;
        end
      end
      S_WAIT_ACK: begin
        timer_d = timer_q + 1'b1;
        if (rx_seg_valid && rx_seg_flag[4]) begin
          done_d  = 1'b1;
          state_d = S_ESTAB;
        end else if (timeout) begin
          retx = 1'b1;
        end
      end
      S_FIN_WAIT_1: begin
        timer_d = timer_q + 1'b1;
        if (rx_seg_valid && rx_seg_flag[4] && rx_seg_flag[0]) begin
          enc_en_d   = 1'b1;
          enc_flag_d = FL_ACK;
          state_d    = S_TIME_WAIT;
        end else if (rx_seg_valid && rx_seg_flag[4]) begin
          state_d = S_FIN_WAIT_2;
        end else if (timeout) begin
          retx = 1'b1;
        end
      end
      S_FIN_WAIT_2: begin
        timer_d = timer_q + 1'b1;
        if (rx_seg_valid && rx_seg_flag[0]) begin
          enc_en_d   = 1'b1;
          enc_flag_d = FL_ACK;
          state_d    = S_TIME_WAIT;
        end else if (timeout) begin
          state_d = S_CLOSED;
        end
      end
      S_TIME_WAIT: begin
        tw_d = tw_q + 1'b1;
        if (tw_q == TW_W'(TIME_WAIT_CYCLES - 1)) begin
          state_d = S_CLOSED;
        end
      end
      default: state_d = S_CLOSED;
    endcase

    // Retransmit reuses the held flag set and payload; each of these states
    // was entered by issuing exactly the segment that now needs repeating.
    if (retx) begin
      if (retry_q < RTY_W'(MAX_RETRY)) begin
        enc_en_d = 1'b1;
        retry_d  = retry_q + 1'b1;
      end else begin
        state_d = S_CLOSED;
        err_d   = 1'b1;
      end
    end

    // A peer reset overrides every other flag and aborts without a segment.
    if (peer_rst && state_q != S_CLOSED) begin
      state_d    = S_CLOSED;
      enc_en_d   = 1'b0;
      enc_flag_d = enc_flag_q;
      enc_data_d = enc_data_q;
      done_d     = 1'b0;
      err_d      = 1'b1;
    end

    if (enc_en_d || state_d != state_q) timer_d = '0;
    if (state_d != state_q) retry_d = '0;
  end

  // Register all state and outputs; synchronous reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_CLOSED;
      timer_q    <= '0;
      tw_q       <= '0;
      retry_q    <= '0;
      enc_en_q   <= 1'b0;
      enc_flag_q <= '0;
      // NOTE: the payload buffer is reset too because it drives a visible output port.
      enc_data_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      tw_q       <= tw_d;
      retry_q    <= retry_d;
      enc_en_q   <= enc_en_d;
      enc_flag_q <= enc_flag_d;
      enc_data_q <= enc_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign state       = state_q;
  assign enc_en      = enc_en_q;
  assign enc_flag    = enc_flag_q;
  assign enc_data    = enc_data_q;
  assign tx_done     = done_q;
  assign conn_err    = err_q;
  assign tx_ready    = (state_q == S_ESTAB);
  assign established = (state_q == S_ESTAB) || (state_q == S_WAIT_ACK);

endmodule
